// File: rtl/glove_pkg.sv
// Shared definitions for the glove tracker slice.
// Holds the frame-processing state encoding, the per-frame observation
// classes, the divider latency and the area classifier.
package glove_pkg;

  typedef enum logic [2:0] {IDLE, DIV_X, DIV_Y, SCALE, OUT} state_t;

  typedef enum logic [1:0] {OBS_LOST, OBS_CLOSED, OBS_OPEN} obs_t;

  localparam int DIV_CYCLES = 32;

  // Area thresholds: below min_area the glove is not visible; a small
  // visible blob is a fist, a large one is an open hand.
  function automatic obs_t classify(input logic [19:0] count,
                                    input logic [19:0] min_area,
                                    input logic [19:0] open_area);
    if (count < min_area) return OBS_LOST;
    else if (count < open_area) return OBS_CLOSED;
    else return OBS_OPEN;
  endfunction

endpackage

// File: rtl/glove_tracker_seq_divider.sv
// Restoring unsigned divider, 32-bit dividend by 20-bit divisor.
// The first quotient bit is resolved on the start edge itself, so done
// is high exactly DIV_CYCLES cycles after start; quotient holds its value
// until the next start. A new start may coincide with done.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   start              load operands and begin a division
//   dividend, divisor  operands, sampled on start (divisor must be nonzero)
//   busy               division in progress
//   done               one-cycle pulse, quotient valid
//   quotient           floored quotient
module seq_divider
  import glove_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [19:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient
);

  localparam logic [4:0] LAST_STEP = 5'(DIV_CYCLES - 1);

  logic [19:0] rem;
  logic [19:0] div_q;
  logic [4:0]  step_cnt;
  logic [19:0] rem_in;
  logic [31:0] quo_in;
  logic [19:0] dsr;
  logic [20:0] trial;
  logic [19:0] rem_nx;
  logic [31:0] quo_nx;

  // One restoring step; on start it works directly on the new operands.
  // The quotient register doubles as the dividend shift register.
  always_comb begin
    rem_in = start ? 20'd0 : rem;
    quo_in = start ? dividend : quotient;
    dsr    = start ? divisor : div_q;
    trial  = {rem_in, quo_in[31]};
    if (trial >= {1'b0, dsr}) begin
      rem_nx = 20'(trial - {1'b0, dsr});
      quo_nx = {quo_in[30:0], 1'b1};
    end else begin
      rem_nx = trial[19:0];
      quo_nx = {quo_in[30:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem      <= '0;
      div_q    <= '0;
      quotient <= '0;
      step_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem      <= rem_nx;
        quotient <= quo_nx;
        div_q    <= divisor;
        step_cnt <= 5'd1;
        busy     <= 1'b1;
      end else if (busy) begin
        rem      <= rem_nx;
        quotient <= quo_nx;
        step_cnt <= step_cnt + 5'd1;
        if (step_cnt == LAST_STEP) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/glove_tracker.sv
// Glove tracker: accumulates colour-matched pixels over a frame, finds the
// blob centroid with a shared sequential divider, converts it to mm (y up,
// floor = 0), classifies the blob area and debounces the hand state.
// Results appear 66 cycles after frame_end, together with the update pulse.
// Optional: define GLOVE_SMOOTH_EN to pass position through a 1/4-gain IIR.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   pix_valid, hcount, vcount  active-video pixel strobe and coordinates
//   match                      pixel matches glove colour
//   frame_end                  pulse after the last active pixel
//   glove_x, glove_y           position in mm
//   glove_closed, can_catch    debounced hand state, catch permission
//   glove_valid                last frame had enough matched pixels
//   update                     pulse when results are refreshed
//   frame_dropped              pulse when a frame ended during computation
module glove_tracker
  import glove_pkg::*;
#(
  parameter int MM_PER_PIX      = 6,
  parameter int V_ACTIVE        = 768,
  parameter int Y_OFFSET_MM     = 0,
  parameter int MIN_AREA        = 50,
  parameter int OPEN_AREA       = 400,
  parameter int DEBOUNCE        = 3,
  parameter int MIN_OPEN_FRAMES = 4
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_valid,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic        match,
  input  logic        frame_end,
  output logic [15:0] glove_x,
  output logic [15:0] glove_y,
  output logic        glove_closed,
  output logic        can_catch,
  output logic        glove_valid,
  output logic        update,
  output logic        frame_dropped
);

  localparam logic [31:0] MM_U     = 32'(MM_PER_PIX);
  localparam logic [31:0] VMAX_U   = 32'(V_ACTIVE - 1);
  localparam logic [31:0] YOFF_U   = 32'(Y_OFFSET_MM);
  localparam logic [19:0] MIN_A    = 20'(MIN_AREA);
  localparam logic [19:0] OPEN_A   = 20'(OPEN_AREA);
  localparam logic [7:0]  DB_LIM   = 8'(DEBOUNCE);
  localparam logic [7:0]  OPEN_LIM = 8'(MIN_OPEN_FRAMES);

  state_t      state, state_nx;
  logic [31:0] sum_x, sum_y, sum_x_in, sum_y_in;
  logic [19:0] count, count_in;
  logic        hit;
  logic [31:0] snap_sum_y, cx;
  logic [19:0] snap_count;
  logic        div_start, div_busy, div_done;
  logic [31:0] div_dividend, div_quotient;
  logic [19:0] div_divisor;
  logic [15:0] x_raw, y_raw, x_nx, y_nx;
  obs_t        obs;
  logic        closed_nx, rise, catch_nx;
  logic [7:0]  db_cnt, db_nx, streak, streak_nx;

  // Running sums including the current pixel; a pixel on the frame_end
  // cycle still belongs to the frame that is ending.
  always_comb begin
    hit      = pix_valid && match;
    sum_x_in = sum_x + (hit ? 32'(hcount) : 32'd0);
    sum_y_in = sum_y + (hit ? 32'(vcount) : 32'd0);
    count_in = (hit && count != 20'hFFFFF) ? count + 20'd1 : count;
  end

  // Every frame_end starts a fresh frame, whether or not it is processed.
  always_ff @(posedge clk) begin
    if (reset || frame_end) begin
      sum_x <= '0;
      sum_y <= '0;
      count <= '0;
    end else begin
      sum_x <= sum_x_in;
      sum_y <= sum_y_in;
      count <= count_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // The divider is started for x straight from the live sums, then reused
  // for y from the snapshot; a zero count divides by one instead.
  always_comb begin
    state_nx     = state;
    div_start    = 1'b0;
    div_dividend = sum_x_in;
    div_divisor  = (count_in == 20'd0) ? 20'd1 : count_in;
    case (state)
      IDLE: if (frame_end) begin
        div_start = 1'b1;
        state_nx  = DIV_X;
      end
      DIV_X: if (div_done) begin
        div_start    = 1'b1;
        div_dividend = snap_sum_y;
        div_divisor  = (snap_count == 20'd0) ? 20'd1 : snap_count;
        state_nx     = DIV_Y;
      end
      DIV_Y: if (div_done) state_nx = SCALE;
      SCALE: state_nx = OUT;
      OUT:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      snap_sum_y <= '0;
      snap_count <= '0;
      cx         <= '0;
    end else begin
      if (state == IDLE && frame_end) begin
        snap_sum_y <= sum_y_in;
        snap_count <= count_in;
      end
      if (state == DIV_X && div_done) cx <= div_quotient;
    end
  end

  seq_divider u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quotient)
  );

  // In SCALE the divider still holds the y quotient.
  always_comb begin
    x_raw = 16'(cx * MM_U);
    y_raw = 16'((VMAX_U - div_quotient) * MM_U + YOFF_U);
    obs   = classify(snap_count, MIN_A, OPEN_A);
  end

`ifdef GLOVE_SMOOTH_EN
  logic              pos_loaded;
  logic signed [16:0] dx, dy;

  // First valid frame after reset or loss loads directly.
  always_comb begin
    dx = $signed({1'b0, x_raw}) - $signed({1'b0, glove_x});
    dy = $signed({1'b0, y_raw}) - $signed({1'b0, glove_y});
    if (pos_loaded) begin
      x_nx = glove_x + 16'(dx >>> 2);
      y_nx = glove_y + 16'(dy >>> 2);
    end else begin
      x_nx = x_raw;
      y_nx = y_raw;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)               pos_loaded <= 1'b0;
    else if (state == SCALE) pos_loaded <= (obs != OBS_LOST);
  end
`else
  always_comb begin
    x_nx = x_raw;
    y_nx = y_raw;
  end
`endif

  // Debounce and catch arming use the register values from before this
  // frame; a closing hand keeps whatever arming it had when it closed.
  always_comb begin
    closed_nx = glove_closed;
    db_nx     = 8'd0;
    if ((obs == OBS_CLOSED) != glove_closed) begin
      if (db_cnt + 8'd1 >= DB_LIM) closed_nx = ~glove_closed;
      else                         db_nx     = db_cnt + 8'd1;
    end
    rise      = closed_nx && !glove_closed;
    streak_nx = streak;
    if (rise)                                  streak_nx = 8'd0;
    else if (!glove_closed && streak != 8'hFF) streak_nx = streak + 8'd1;
    catch_nx = can_catch;
    if (!rise && !closed_nx) catch_nx = (streak >= OPEN_LIM);
  end

  // Results are loaded leaving SCALE so they are visible with update.
  always_ff @(posedge clk) begin
    if (reset) begin
      glove_x       <= '0;
      glove_y       <= '0;
      glove_closed  <= 1'b0;
      can_catch     <= 1'b0;
      glove_valid   <= 1'b0;
      update        <= 1'b0;
      frame_dropped <= 1'b0;
      db_cnt        <= '0;
      streak        <= '0;
    end else begin
      update        <= (state == SCALE);
      frame_dropped <= frame_end && (state != IDLE || div_busy);
      if (state == SCALE) begin
        if (obs == OBS_LOST) begin
          glove_valid <= 1'b0;
          can_catch   <= 1'b0;
          db_cnt      <= '0;
          streak      <= '0;
        end else begin
          glove_valid  <= 1'b1;
          glove_x      <= x_nx;
          glove_y      <= y_nx;
          glove_closed <= closed_nx;
          can_catch    <= catch_nx;
          db_cnt       <= db_nx;
          streak       <= streak_nx;
        end
      end
    end
  end

endmodule

// File: tb/tb_glove_tracker.sv
// Directed bench for glove_tracker: frames of matched pixel blocks are
// driven, expected results are queued at frame_end and compared when
// update arrives.
module tb_glove_tracker;

  logic        clk = 1'b0;
  logic        reset, pix_valid, match, frame_end;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic [15:0] glove_x, glove_y;
  logic        glove_closed, can_catch, glove_valid, update, frame_dropped;

  glove_tracker dut (
    .clk           (clk),
    .reset         (reset),
    .pix_valid     (pix_valid),
    .hcount        (hcount),
    .vcount        (vcount),
    .match         (match),
    .frame_end     (frame_end),
    .glove_x       (glove_x),
    .glove_y       (glove_y),
    .glove_closed  (glove_closed),
    .can_catch     (can_catch),
    .glove_valid   (glove_valid),
    .update        (update),
    .frame_dropped (frame_dropped)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic        valid;
    logic        closed;
    logic        cc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_assert = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          fe_cyc = 0;
  logic [15:0] last_x = 16'd0;
  logic [15:0] last_y = 16'd0;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_assert++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_x"}, 32'(glove_x), 0);
    check({tag, "_y"}, 32'(glove_y), 0);
    check({tag, "_valid"}, 32'(glove_valid), 0);
    check({tag, "_closed"}, 32'(glove_closed), 0);
    check({tag, "_catch"}, 32'(can_catch), 0);
    check({tag, "_update"}, 32'(update), 0);
    check({tag, "_dropped"}, 32'(frame_dropped), 0);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    last_x = 16'd0;
    last_y = 16'd0;
    check_zero_outputs("reset");
  endtask

  // Drives a w x ht block of matched pixels; the last pixel shares the
  // frame_end cycle. With push set, the expected result is queued.
  task automatic send_frame(input int h0, input int v0, input int w,
                            input int ht, input bit push,
                            input bit exp_closed, input bit exp_cc);
    longint sx = 0;
    longint sy = 0;
    int     n = w * ht;
    int     k = 0;
    exp_t   e;
    for (int j = 0; j < ht; j++) begin
      for (int i = 0; i < w; i++) begin
        pix_valid = 1'b1;
        match     = 1'b1;
        hcount    = 11'(h0 + i);
        vcount    = 10'(v0 + j);
        sx += h0 + i;
        sy += v0 + j;
        k++;
        if (k == n) begin
          frame_end = 1'b1;
          fe_cyc    = cyc;
        end
        tick();
      end
    end
    if (n == 0) begin
      frame_end = 1'b1;
      fe_cyc    = cyc;
      tick();
    end
    pix_valid = 1'b0;
    match     = 1'b0;
    frame_end = 1'b0;
    if (push) begin
      if (n >= 50) begin
        last_x  = 16'((sx / n) * 6);
        last_y  = 16'((767 - (sy / n)) * 6);
        e.valid = 1'b1;
      end else begin
        e.valid = 1'b0;
      end
      e.x      = last_x;
      e.y      = last_y;
      e.closed = exp_closed;
      e.cc     = exp_cc;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_update(input string tag);
    exp_t e;
    while (update !== 1'b1 && (cyc - fe_cyc) < 100) tick();
    check({tag, "_update_seen"}, 32'(update), 1);
    check({tag, "_latency"}, 32'(cyc - fe_cyc), 66);
    check({tag, "_queue_nonempty"}, 32'(exp_q.size() != 0), 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, "_x"}, 32'(glove_x), 32'(e.x));
      check({tag, "_y"}, 32'(glove_y), 32'(e.y));
      check({tag, "_valid"}, 32'(glove_valid), 32'(e.valid));
      check({tag, "_closed"}, 32'(glove_closed), 32'(e.closed));
      check({tag, "_catch"}, 32'(can_catch), 32'(e.cc));
    end
    tick();
    check({tag, "_update_width"}, 32'(update), 0);
  endtask

  initial begin
    int seen;
    reset     = 1'b1;
    pix_valid = 1'b0;
    match     = 1'b0;
    frame_end = 1'b0;
    hcount    = '0;
    vcount    = '0;

    // Basic centroid: 10x10 block -> cx 104, cy 204
    apply_reset();
    send_frame(100, 200, 10, 10, 1, 0, 0);
    wait_update("centroid");
    check("centroid_x_const", 32'(glove_x), 624);
    check("centroid_y_const", 32'(glove_y), 3378);

    // Four open frames, then three closed: armed before and after closing
    apply_reset();
    for (int f = 0; f < 4; f++) begin
      send_frame(300, 100, 25, 20, 1, 0, 0);
      wait_update("open_streak");
    end
    send_frame(100, 200, 10, 10, 1, 0, 1);
    wait_update("close_1");
    send_frame(100, 200, 10, 10, 1, 0, 1);
    wait_update("close_2");
    send_frame(100, 200, 10, 10, 1, 1, 1);
    wait_update("close_3");

    // Lost frames hold position and closed state, drop catch permission
    send_frame(400, 400, 10, 1, 1, 1, 0);
    wait_update("lost_small");
    send_frame(0, 0, 0, 0, 1, 1, 0);
    wait_update("lost_empty");

    // Short open streak: closing leaves catch disarmed
    apply_reset();
    send_frame(300, 100, 25, 20, 1, 0, 0);
    wait_update("short_open_1");
    send_frame(300, 100, 25, 20, 1, 0, 0);
    wait_update("short_open_2");
    send_frame(100, 200, 10, 10, 1, 0, 0);
    wait_update("short_close_1");
    send_frame(100, 200, 10, 10, 1, 0, 0);
    wait_update("short_close_2");
    send_frame(100, 200, 10, 10, 1, 1, 0);
    wait_update("short_close_3");

    // Frame ending during computation is dropped and its pixels discarded
    apply_reset();
    send_frame(100, 200, 10, 10, 1, 0, 0);
    while ((cyc - fe_cyc) < 20) begin
      pix_valid = 1'b1;
      match     = 1'b1;
      hcount    = 11'd1000;
      vcount    = 10'd700;
      tick();
    end
    pix_valid = 1'b0;
    match     = 1'b0;
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    check("dropped_pulse", 32'(frame_dropped), 1);
    tick();
    check("dropped_width", 32'(frame_dropped), 0);
    wait_update("before_drop");
    send_frame(500, 50, 10, 10, 1, 0, 0);
    wait_update("after_drop");

    // Reset during the y division aborts the frame
    send_frame(120, 300, 10, 10, 0, 0, 0);
    while ((cyc - fe_cyc) < 40) tick();
    reset = 1'b1;
    tick();
    check_zero_outputs("abort");
    reset  = 1'b0;
    last_x = 16'd0;
    last_y = 16'd0;
    seen   = 0;
    repeat (80) begin
      tick();
      if (update === 1'b1) seen++;
    end
    check("abort_no_update", 32'(seen), 0);

    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
